// File: rtl/boot_loader_ctrl_if.sv
// ROM read port and IMEM write port seen by the boot sequencer.
// The master side is the sequencer; the slave side is the memory subsystem.
interface boot_loader_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              imem_ready;

  modport master (
    output rom_rd, rom_addr, imem_we, imem_addr, imem_wdata,
    input  rom_data, imem_ready
  );

  modport slave (
    input  rom_rd, rom_addr, imem_we, imem_addr, imem_wdata,
    output rom_data, imem_ready
  );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Post-reset boot sequencer: copies the ROM program image into IMEM, verifies the
// trailing checksum word, then releases the CPU or parks it in reset with an error.
module boot_loader_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int BOOT_WORDS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               boot_en,
  boot_loader_ctrl_if.master bus,
  output logic               cpu_rst,
  output logic               boot_busy,
  output logic               boot_done,
  output logic               boot_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_READ_CK, S_CHECK, S_RUN, S_ERROR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BOOT_WORDS - 1);
  localparam logic [ADDR_W-1:0] CK_ADDR  = ADDR_W'(BOOT_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  logic              rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;

    unique case (state_q)
      S_IDLE:    state_d = boot_en ? S_READ : S_RUN;
      S_READ:    state_d = S_WRITE;
      S_WRITE: begin
        if (bus.imem_ready) begin
          sum_d = sum_q + bus.rom_data;
          if (idx_q == LAST_IDX) begin
            state_d = S_READ_CK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_READ_CK: state_d = S_CHECK;
      S_CHECK:   state_d = (bus.rom_data == sum_q) ? S_RUN : S_ERROR;
      default:   state_d = state_q;
    endcase

    // Outputs are decoded from the next state so the registered copy lines up with the state.
    rom_rd_d    = (state_d == S_READ) || (state_d == S_READ_CK);
    rom_addr_d  = '0;
    if (state_d == S_READ)    rom_addr_d = idx_d;
    if (state_d == S_READ_CK) rom_addr_d = CK_ADDR;
    imem_we_d   = (state_d == S_WRITE);
    imem_addr_d = (state_d == S_WRITE) ? idx_d : '0;
    busy_d      = (state_d == S_READ) || (state_d == S_WRITE) ||
                  (state_d == S_READ_CK) || (state_d == S_CHECK);
    done_d      = (state_d == S_RUN);
    err_d       = (state_d == S_ERROR);
    cpu_rst_d   = (state_d != S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.rom_rd     = rom_rd_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  // Write data flows straight from the ROM output register while in WRITE.
  assign bus.imem_wdata = imem_we_q ? bus.rom_data : '0;
  assign cpu_rst        = cpu_rst_q;
  assign boot_busy      = busy_q;
  assign boot_done      = done_q;
  assign boot_err       = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Randomized self-checking bench for boot_loader_ctrl: a per-cycle expected timeline is
// built from the boot rules and compared against the DUT outputs every cycle.
module tb_boot_loader_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int BW     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic boot_en = 1'b0;
  logic cpu_rst, boot_busy, boot_done, boot_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  boot_loader_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOOT_WORDS(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .boot_en   (boot_en),
    .bus       (bus.master),
    .cpu_rst   (cpu_rst),
    .boot_busy (boot_busy),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  // Memory models: synchronous ROM, IMEM capturing accepted writes.
  logic [DATA_W-1:0] rom  [0:BW];
  logic [DATA_W-1:0] imem [0:BW-1];
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (rst) bus.rom_data <= '0;
    else if (bus.rom_rd) bus.rom_data <= (bus.rom_addr <= BW) ? rom[bus.rom_addr] : 32'hDEAD_BEEF;
    if (!rst && bus.imem_we && bus.imem_ready) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.imem_addr < BW) imem[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  typedef struct {
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy, done, err, cpu_rst;
  } exp_t;

  exp_t tl[$];
  bit   rdy[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(bit rd, int raddr, bit we, int waddr, logic [DATA_W-1:0] wd,
                               bit busy, bit done, bit err, bit cr, bit ready);
    exp_t e;
    e.rom_rd = rd;  e.rom_addr = ADDR_W'(raddr);
    e.we = we;      e.waddr = ADDR_W'(waddr);  e.wdata = wd;
    e.busy = busy;  e.done = done;  e.err = err;  e.cpu_rst = cr;
    tl.push_back(e);
    rdy.push_back(ready);
  endfunction

  // One boot: reset pulse, then cycle-by-cycle comparison. abort_at >= 0 raises rst in that cycle.
  task automatic run(input bit en, input int st[BW], input int abort_at);
    logic [DATA_W-1:0] sum;
    bit exp_err;
    int wr0;
    sum = '0;
    for (int k = 0; k < BW; k++) sum += rom[k];
    exp_err = en && (rom[BW] != sum);
    tl.delete();
    rdy.delete();

    push(0, 0, 0, 0, '0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
    if (en) begin
      for (int k = 0; k < BW; k++) begin
        push(1, k, 0, 0, '0, 1, 0, 0, 1, 1'($urandom_range(0, 1)));
        for (int j = 0; j <= st[k]; j++) push(0, 0, 1, k, rom[k], 1, 0, 0, 1, j == st[k]);
      end
      push(1, BW, 0, 0, '0, 1, 0, 0, 1, 1'($urandom_range(0, 1)));
      push(0, 0, 0, 0, '0, 1, 0, 0, 1, 1'($urandom_range(0, 1)));
    end
    for (int t = 0; t < 3; t++)
      push(0, 0, 0, 0, '0, 0, !exp_err, exp_err, exp_err, 1'($urandom_range(0, 1)));

    rst = 1'b1;
    boot_en = en;
    @(posedge clk);
    #1 rst = 1'b0;
    wr0 = wr_cnt;

    for (int c = 0; c < tl.size(); c++) begin
      @(negedge clk);
      check($sformatf("c%0d rom_rd", c), bus.rom_rd, tl[c].rom_rd);
      check($sformatf("c%0d rom_addr", c), bus.rom_addr, tl[c].rom_addr);
      check($sformatf("c%0d imem_we", c), bus.imem_we, tl[c].we);
      check($sformatf("c%0d imem_addr", c), bus.imem_addr, tl[c].waddr);
      check($sformatf("c%0d imem_wdata", c), bus.imem_wdata, tl[c].wdata);
      check($sformatf("c%0d boot_busy", c), boot_busy, tl[c].busy);
      check($sformatf("c%0d boot_done", c), boot_done, tl[c].done);
      check($sformatf("c%0d boot_err", c), boot_err, tl[c].err);
      check($sformatf("c%0d cpu_rst", c), cpu_rst, tl[c].cpu_rst);
      if (c == abort_at) begin
        rst = 1'b1;
        return;
      end
      bus.imem_ready = rdy[c];
      if (c > 0) boot_en = 1'($urandom_range(0, 1));
    end

    check("write_count", 64'(wr_cnt - wr0), en ? 64'(BW) : 64'd0);
    if (en)
      for (int k = 0; k < BW; k++) check($sformatf("imem[%0d]", k), imem[k], rom[k]);
  endtask

  task automatic load_rom(input logic [DATA_W-1:0] w0, w1, w2, w3, ck);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = ck;
  endtask

  initial begin
    int st[BW];
    logic [DATA_W-1:0] s;
    bus.imem_ready = 1'b1;

    load_rom(1, 2, 3, 4, 10);
    run(1, '{0, 0, 0, 0}, -1);               // clean boot, RUN at c11
    load_rom(1, 2, 3, 4, 11);
    run(1, '{0, 0, 0, 0}, -1);               // checksum mismatch, ERROR at c11
    load_rom(1, 2, 3, 4, 10);
    run(1, '{0, 0, 3, 0}, -1);               // three stall cycles on word 2, RUN at c14
    run(0, '{0, 0, 0, 0}, -1);               // skip straight to RUN
    run(1, '{0, 0, 0, 0}, 8);                // reset during word-3 WRITE
    run(1, '{0, 0, 0, 0}, -1);               // reboot from word 0
    load_rom(32'hFFFF_FFFF, 2, 0, 0, 1);
    run(1, '{0, 0, 0, 0}, -1);               // sum wraps modulo 2^32

    for (int n = 0; n < 20; n++) begin
      s = '0;
      for (int k = 0; k < BW; k++) begin
        rom[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + DATA_W'($urandom_range(0, 15))
                                             : DATA_W'($urandom);
        s += rom[k];
        st[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      end
      rom[BW] = ($urandom_range(0, 2) == 0) ? s + DATA_W'($urandom_range(1, 1000)) : s;
      run($urandom_range(0, 5) != 0, st, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : -1);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
